// File: rtl/enc_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : enc_gate_ctrl
// Description : Gated encoder pulse counter. Counts ENCA rising edges over a
//               programmable window and hands results over a valid/ack pair.
// Revision    : 1.0 - initial release
// ============================================================================
module enc_gate_ctrl #(
  parameter int CNT_W = 16,
  parameter int WIN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIN_W-1:0] win_len,
  input  logic             ENCA,
  output logic [CNT_W-1:0] cnt_out,
  output logic             cnt_valid,
  input  logic             cnt_ack,
  output logic             ovf,
  output logic             lost,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
  localparam logic [WIN_W-1:0] C_WIN_MIN = WIN_W'(2);
  localparam logic [WIN_W-1:0] C_WIN_ONE = WIN_W'(1);

  state_t           r_state;
  logic             r_busy;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_sync_d;
  logic [CNT_W-1:0] r_pulse;
  logic             r_win_ovf;
  logic [WIN_W-1:0] r_win_cnt;
  logic [CNT_W-1:0] r_cnt_out;
  logic             r_cnt_valid;
  logic             r_ovf;
  logic             r_lost;

  logic             w_edge;
  logic             w_sat;
  logic [CNT_W-1:0] w_pulse_next;
  logic             w_ovf_next;
  logic [WIN_W-1:0] w_win_eff;
  logic             w_last;
  logic             w_ack_ok;

  assign w_edge       = r_sync2 & ~r_sync_d;
  assign w_sat        = (r_pulse == C_CNT_MAX);
  assign w_pulse_next = (w_edge && !w_sat) ? (r_pulse + CNT_W'(1)) : r_pulse;
  assign w_ovf_next   = r_win_ovf | (w_edge & w_sat);
  // Windows shorter than two cycles are stretched to two.
  assign w_win_eff    = (win_len < C_WIN_MIN) ? C_WIN_MIN : win_len;
  assign w_last       = (r_state == COUNT) && (r_win_cnt == C_WIN_ONE);
  assign w_ack_ok     = cnt_ack && r_cnt_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_sync_d <= 1'b0;
    end else begin
      r_sync1  <= ENCA;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_busy    <= 1'b0;
      r_pulse   <= '0;
      r_win_ovf <= 1'b0;
      r_win_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (en) begin
            r_state <= ARM;
            r_busy  <= 1'b1;
          end
        end
        ARM: begin
          r_win_cnt <= w_win_eff;
          r_pulse   <= '0;
          r_win_ovf <= 1'b0;
          r_state   <= COUNT;
          r_busy    <= 1'b1;
        end
        COUNT: begin
          if (r_win_cnt == C_WIN_ONE) begin
            // Last cycle: result is captured by the output block; restart or stop.
            r_pulse   <= '0;
            r_win_ovf <= 1'b0;
            if (en) begin
              r_win_cnt <= w_win_eff;
            end else begin
              r_win_cnt <= '0;
              r_state   <= IDLE;
              r_busy    <= 1'b0;
            end
          end else if (!en) begin
            r_pulse   <= '0;
            r_win_ovf <= 1'b0;
            r_win_cnt <= '0;
            r_state   <= IDLE;
            r_busy    <= 1'b0;
          end else begin
            r_win_cnt <= r_win_cnt - C_WIN_ONE;
            r_pulse   <= w_pulse_next;
            r_win_ovf <= w_ovf_next;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt_out   <= '0;
      r_cnt_valid <= 1'b0;
      r_ovf       <= 1'b0;
      r_lost      <= 1'b0;
    end else begin
      if (w_last) begin
        r_cnt_out   <= w_pulse_next;
        r_ovf       <= w_ovf_next;
        r_cnt_valid <= 1'b1;
      end else if (w_ack_ok) begin
        r_cnt_valid <= 1'b0;
      end
      // An overwrite of an unconsumed result beats a concurrent clear.
      if (w_last && r_cnt_valid && !cnt_ack) begin
        r_lost <= 1'b1;
      end else if (w_ack_ok) begin
        r_lost <= 1'b0;
      end
    end
  end

  assign cnt_out   = r_cnt_out;
  assign cnt_valid = r_cnt_valid;
  assign ovf       = r_ovf;
  assign lost      = r_lost;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_enc_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_enc_gate_ctrl
// Description : Directed self-checking bench for enc_gate_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_enc_gate_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] win_len = 16'd100;
  logic        ENCA = 1'b0;
  logic        cnt_ack = 1'b0;

  logic [15:0] cnt_out;
  logic        cnt_valid, ovf, lost, busy;
  logic [3:0]  cnt_out4;
  logic        cnt_valid4, ovf4, lost4, busy4;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ph = 0;
  int mode = 0;  // 0: ENCA low, 1: period 4, 2: period 2

  enc_gate_ctrl #(.CNT_W(16), .WIN_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .win_len(win_len), .ENCA(ENCA),
    .cnt_out(cnt_out), .cnt_valid(cnt_valid), .cnt_ack(cnt_ack),
    .ovf(ovf), .lost(lost), .busy(busy)
  );

  enc_gate_ctrl #(.CNT_W(4), .WIN_W(16)) dut4 (
    .clk(clk), .rst(rst), .en(en), .win_len(win_len), .ENCA(ENCA),
    .cnt_out(cnt_out4), .cnt_valid(cnt_valid4), .cnt_ack(cnt_ack),
    .ovf(ovf4), .lost(lost4), .busy(busy4)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    ph = ph + 1;
    if (mode == 1)      ENCA = ph[1];
    else if (mode == 2) ENCA = ph[0];
    else                ENCA = 1'b0;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  // Leaves the DUT idle with a settled synchronizer; cyc=0 marks the point where en is raised.
  task automatic do_reset();
    rst = 1'b1; en = 1'b0; cnt_ack = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (5) tick();
    cyc = 0;
  endtask

  task automatic test_reset();
    mode = 2; win_len = 16'd100;
    rst = 1'b1; en = 1'b1; cnt_ack = 1'b1;
    repeat (4) tick();
    total++; if (cnt_out !== 16'd0) begin bad++; $display("FAIL reset_cnt_out: got %0d want 0", cnt_out); end
    total++; if ({cnt_valid, ovf, lost, busy} !== 4'b0000) begin bad++; $display("FAIL reset_flags: got %b want 0000", {cnt_valid, ovf, lost, busy}); end
    total++; if ({cnt_out4, cnt_valid4, ovf4, lost4, busy4} !== 8'h00) begin bad++; $display("FAIL reset_dut4: got %h want 00", {cnt_out4, cnt_valid4, ovf4, lost4, busy4}); end
    rst = 1'b0; cnt_ack = 1'b0;
    tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_release_arm: busy got %b want 1", busy); end
  endtask

  task automatic test_steady();
    mode = 1; win_len = 16'd100;
    do_reset();
    en = 1'b1;
    wait_until(101);
    total++; if (cnt_valid !== 1'b0) begin bad++; $display("FAIL steady_early: valid got %b want 0", cnt_valid); end
    wait_until(102);
    total++; if ({cnt_valid, ovf} !== 2'b10) begin bad++; $display("FAIL steady_flags1: got %b want 10", {cnt_valid, ovf}); end
    total++; if (cnt_out !== 16'd25) begin bad++; $display("FAIL steady_cnt1: got %0d want 25", cnt_out); end
    cnt_ack = 1'b1; tick(); cnt_ack = 1'b0;
    total++; if (cnt_valid !== 1'b0) begin bad++; $display("FAIL steady_ack: valid got %b want 0", cnt_valid); end
    wait_until(201);
    total++; if (cnt_valid !== 1'b0) begin bad++; $display("FAIL steady_gap: valid got %b want 0", cnt_valid); end
    wait_until(202);
    total++; if ({cnt_valid, ovf, lost} !== 3'b100) begin bad++; $display("FAIL steady_flags2: got %b want 100", {cnt_valid, ovf, lost}); end
    total++; if (cnt_out !== 16'd25) begin bad++; $display("FAIL steady_cnt2: got %0d want 25", cnt_out); end
  endtask

  task automatic test_saturation();
    mode = 2; win_len = 16'd100;
    do_reset();
    en = 1'b1;
    wait_until(90);
    mode = 0;
    wait_until(102);
    total++; if (cnt_out4 !== 4'd15) begin bad++; $display("FAIL sat_cnt: got %0d want 15", cnt_out4); end
    total++; if ({cnt_valid4, ovf4} !== 2'b11) begin bad++; $display("FAIL sat_ovf: got %b want 11", {cnt_valid4, ovf4}); end
    cnt_ack = 1'b1; tick(); cnt_ack = 1'b0;
    wait_until(202);
    total++; if (cnt_out4 !== 4'd0) begin bad++; $display("FAIL sat_quiet_cnt: got %0d want 0", cnt_out4); end
    total++; if ({cnt_valid4, ovf4, lost4} !== 3'b100) begin bad++; $display("FAIL sat_quiet_flags: got %b want 100", {cnt_valid4, ovf4, lost4}); end
  endtask

  task automatic test_overrun_winlen();
    mode = 1; win_len = 16'd100;
    do_reset();
    en = 1'b1;
    wait_until(50);
    win_len = 16'd20;
    wait_until(101);
    total++; if (cnt_valid !== 1'b0) begin bad++; $display("FAIL winlen_still100: valid got %b want 0", cnt_valid); end
    wait_until(102);
    total++; if (cnt_out !== 16'd25) begin bad++; $display("FAIL ovr_first: got %0d want 25", cnt_out); end
    wait_until(121);
    total++; if ({cnt_valid, lost, cnt_out} !== {2'b10, 16'd25}) begin bad++; $display("FAIL ovr_before: got %b/%0d want 10/25", {cnt_valid, lost}, cnt_out); end
    wait_until(122);
    total++; if ({cnt_valid, lost} !== 2'b11) begin bad++; $display("FAIL ovr_lost: got %b want 11", {cnt_valid, lost}); end
    total++; if (cnt_out !== 16'd5) begin bad++; $display("FAIL ovr_second_cnt: got %0d want 5", cnt_out); end
    cnt_ack = 1'b1; tick(); cnt_ack = 1'b0;
    total++; if ({cnt_valid, lost} !== 2'b00) begin bad++; $display("FAIL ovr_ack_clear: got %b want 00", {cnt_valid, lost}); end
    wait_until(141);
    total++; if (cnt_valid !== 1'b0) begin bad++; $display("FAIL winlen20_gap: valid got %b want 0", cnt_valid); end
    wait_until(142);
    total++; if ({cnt_valid, lost, cnt_out} !== {2'b10, 16'd5}) begin bad++; $display("FAIL winlen20_next: got %b/%0d want 10/5", {cnt_valid, lost}, cnt_out); end
  endtask

  task automatic test_ack_collision();
    mode = 1; win_len = 16'd100;
    do_reset();
    en = 1'b1;
    wait_until(50);
    win_len = 16'd20;
    wait_until(121);
    cnt_ack = 1'b1;
    tick();
    cnt_ack = 1'b0;
    total++; if ({cnt_valid, lost} !== 2'b10) begin bad++; $display("FAIL collide_flags: got %b want 10", {cnt_valid, lost}); end
    total++; if (cnt_out !== 16'd5) begin bad++; $display("FAIL collide_cnt: got %0d want 5", cnt_out); end
    tick();
    total++; if (cnt_valid !== 1'b1) begin bad++; $display("FAIL collide_hold: valid got %b want 1", cnt_valid); end
  endtask

  task automatic test_abort();
    mode = 1; win_len = 16'd100;
    do_reset();
    en = 1'b1;
    wait_until(152);
    total++; if ({busy, cnt_valid, cnt_out} !== {2'b11, 16'd25}) begin bad++; $display("FAIL abort_pre: got %b/%0d want 11/25", {busy, cnt_valid}, cnt_out); end
    en = 1'b0;
    tick();
    total++; if ({busy, cnt_valid, lost} !== 3'b010) begin bad++; $display("FAIL abort_idle: got %b want 010", {busy, cnt_valid, lost}); end
    wait_until(210);
    total++; if ({busy, cnt_valid, lost, cnt_out} !== {3'b010, 16'd25}) begin bad++; $display("FAIL abort_hold: got %b/%0d want 010/25", {busy, cnt_valid, lost}, cnt_out); end
    en = 1'b1;
    wait_until(260);
    rst = 1'b1;
    tick();
    total++; if ({cnt_out, cnt_valid, ovf, lost, busy} !== 20'd0) begin bad++; $display("FAIL abort_rst: got %h want 0", {cnt_out, cnt_valid, ovf, lost, busy}); end
    rst = 1'b0;
    tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_rearm: busy got %b want 1", busy); end
  endtask

  task automatic test_min_window();
    mode = 2; win_len = 16'd0;
    do_reset();
    en = 1'b1;
    wait_until(3);
    total++; if (cnt_valid !== 1'b0) begin bad++; $display("FAIL min_early: valid got %b want 0", cnt_valid); end
    wait_until(4);
    total++; if ({cnt_valid, cnt_out, cnt_out4} !== {1'b1, 16'd1, 4'd1}) begin bad++; $display("FAIL min_first: got %b/%0d/%0d want 1/1/1", cnt_valid, cnt_out, cnt_out4); end
    cnt_ack = 1'b1; tick(); cnt_ack = 1'b0;
    total++; if (cnt_valid !== 1'b0) begin bad++; $display("FAIL min_ack: valid got %b want 0", cnt_valid); end
    tick();
    total++; if ({cnt_valid, cnt_out} !== {1'b1, 16'd1}) begin bad++; $display("FAIL min_second: got %b/%0d want 1/1", cnt_valid, cnt_out); end
    win_len = 16'd1;
    cnt_ack = 1'b1; tick(); cnt_ack = 1'b0;
    tick();
    total++; if (cnt_valid !== 1'b1) begin bad++; $display("FAIL min_third: valid got %b want 1", cnt_valid); end
    cnt_ack = 1'b1; tick(); cnt_ack = 1'b0;
    total++; if (cnt_valid !== 1'b0) begin bad++; $display("FAIL len1_gap: valid got %b want 0", cnt_valid); end
    tick();
    total++; if ({cnt_valid, cnt_out, lost} !== {1'b1, 16'd1, 1'b0}) begin bad++; $display("FAIL len1_window: got %b/%0d/%b want 1/1/0", cnt_valid, cnt_out, lost); end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_saturation();
    test_overrun_winlen();
    test_ack_collision();
    test_abort();
    test_min_window();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/enc_gate_ctrl.md
ENC_GATE_CTRL -- requirements
Module: enc_gate_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, meaning pulse-count and output width in bits.
REQ-002 The block SHALL have parameter WIN_W, default 16, meaning gate-window length register width in bits.
REQ-003 Port clk SHALL be: input, 1 bit, single system clock; all logic on its rising edge.
REQ-004 Port rst SHALL be: input, 1 bit, synchronous, active-high reset.
REQ-005 Port en SHALL be: input, 1 bit, measurement enable.
REQ-006 Port win_len SHALL be: input, WIN_W bits, gate-window length in clk cycles.
REQ-007 Port ENCA SHALL be: input, 1 bit, asynchronous encoder channel A.
REQ-008 Port cnt_out SHALL be: output, CNT_W bits, pulse count of the last completed window.
REQ-009 Port cnt_valid SHALL be: output, 1 bit, cnt_out holds an unacknowledged result.
REQ-010 Port cnt_ack SHALL be: input, 1 bit, consumer acknowledge.
REQ-011 Port ovf SHALL be: output, 1 bit, the result in cnt_out saturated.
REQ-012 Port lost SHALL be: output, 1 bit, sticky flag: an unacknowledged result was overwritten.
REQ-013 Port busy SHALL be: output, 1 bit, FSM is not in IDLE.

Function
REQ-014 ENCA SHALL pass through a 2-FF synchronizer followed by one edge-detect register; a 0->1 transition on the synchronized signal is one edge, counted 3 cycles after the input rises.
REQ-015 The FSM SHALL have states IDLE, ARM and COUNT; busy = (state != IDLE).
REQ-016 IDLE -> ARM SHALL occur when en=1; ARM SHALL last one cycle, load the window counter from win_len, clear the pulse counter, and go to COUNT.
REQ-017 A win_len of 0 or 1 SHALL be treated as 2.
REQ-018 Each window SHALL span exactly the effective win_len cycles of COUNT, and every edge detected in any cycle of the window SHALL be counted in that window.
REQ-019 The pulse counter SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap; the window's overflow bit SHALL be set on any edge while the counter is saturated.
REQ-020 On the last cycle of a window (window counter = 1), the block SHALL register cnt_out <= final count including that cycle's edge, ovf <= the window's overflow bit, and cnt_valid <= 1, all visible the following cycle.
REQ-021 In the last cycle of a window, the block SHALL reload win_len and restart the pulse counter at 0 if en=1 (back-to-back windows, no dead cycle); if en=0 it SHALL go to IDLE.
REQ-022 win_len SHALL be sampled only in ARM and in each window's last cycle, so a mid-window change takes effect in the next window.
REQ-023 If en falls before a window's last cycle, the block SHALL go to IDLE on the next cycle, discard the partial count, and leave cnt_out, ovf, cnt_valid and lost unchanged.
REQ-024 cnt_valid SHALL clear in the cycle after cnt_ack=1 is sampled with cnt_valid=1; cnt_ack while cnt_valid=0 SHALL be ignored.
REQ-025 If a new result latches in the same cycle as an accepted ack, the new result SHALL win, cnt_valid SHALL stay 1, and lost SHALL NOT be set.
REQ-026 If a new result latches while cnt_valid=1 and cnt_ack=0, the block SHALL overwrite cnt_out/ovf and set lost=1.
REQ-027 lost SHALL clear only on an accepted ack, unless REQ-026 sets it in the same cycle, in which case set wins.

Reset
REQ-028 While rst=1, the block SHALL force state=IDLE, cnt_out=0, cnt_valid=0, ovf=0, lost=0, busy=0, synchronizer, edge register, pulse counter and window counter to 0.
REQ-029 rst SHALL take priority over en, cnt_ack and ENCA, and asserting rst mid-window SHALL abort the window with no result.
REQ-030 After rst falls with en=1, the block SHALL enter ARM on the first cycle.

Verification
REQ-031 Steady count: win_len=100, en=1, ENCA square wave with 4-cycle period -> every window reports cnt_out=25, ovf=0, and cnt_valid rises every 100 cycles.
REQ-032 Saturation: CNT_W=4, win_len=100, ENCA period 2 cycles -> cnt_out=15, ovf=1; the next window with ENCA held low -> cnt_out=0, ovf=0.
REQ-033 Handshake/overrun: cnt_ack held 0 across two windows -> lost=1 and cnt_out equals the second window's count; one ack cycle -> cnt_valid=0 and lost=0 the next cycle.
REQ-034 Ack collision: cnt_ack=1 in the exact cycle a new result latches -> cnt_valid stays 1, lost stays 0, and cnt_out holds the new value.
REQ-035 Abort: en dropped at cycle 50 of a 100-cycle window -> IDLE the next cycle, busy=0, cnt_out and cnt_valid unchanged; rst pulsed mid-window -> all outputs 0.
REQ-036 win_len boundary: win_len=0 -> 2-cycle windows; win_len changed from 100 to 20 mid-window -> the current window still takes 100 cycles and the next takes 20.
